// File: rtl/openfire_imem_pkg.sv
// Shared types and constants for the OpenFire instruction-memory responder.
// IMEM_PREFETCH_EN adds a second line entry and the prefetch states.
package openfire_imem_pkg;

  localparam logic [31:0] NopWord = 32'h8000_0000;

`ifdef IMEM_PREFETCH_EN
  localparam int unsigned NumLines = 2;

  typedef enum logic [2:0] {
    StIdle,
    StHi,
    StLo,
    StPfHi,
    StPfLo
  } state_e;
`else
  localparam int unsigned NumLines = 1;

  typedef enum logic [1:0] {
    StIdle,
    StHi,
    StLo
  } state_e;
`endif

endpackage

// File: rtl/openfire_imem_line.sv
// One buffered instruction line: valid bit, word tag and 32-bit data.
// Lookup is combinational; reset invalidates the entry.
module openfire_imem_line #(
  parameter int unsigned TagW = 16
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            we_i,
  input  logic [TagW-1:0] wtag_i,
  input  logic [31:0]     wdata_i,
  input  logic [TagW-1:0] addr_i,
  output logic            hit_o,
  output logic [31:0]     data_o
);

  logic            valid_q;
  logic [TagW-1:0] tag_q;
  logic [31:0]     data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (we_i) begin
      valid_q <= 1'b1;
      tag_q   <= wtag_i;
      data_q  <= wdata_i;
    end
  end

  assign hit_o  = valid_q && (tag_q == addr_i);
  assign data_o = data_q;

endmodule

// File: rtl/openfire_imem_ctrl.sv
// Fetch-side instruction buffer filled from a 16-bit external memory in two beats.
// IMEM_PREFETCH_EN adds a second entry that is filled with the next sequential word.
module openfire_imem_ctrl
  import openfire_imem_pkg::*;
#(
  parameter int unsigned A_SPACE  = 16,
  parameter logic [31:0] NOP_WORD = NopWord
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      imem_addr,
  output logic [31:0]      idata,
  output logic             imem_stall,
  output logic             xmem_req,
  output logic [A_SPACE:0] xmem_addr,
  input  logic             xmem_ack,
  input  logic [15:0]      xmem_rdata
);

  logic [A_SPACE-1:0]  addr_tag;
  state_e              state_q, state_d;
  logic [A_SPACE-1:0]  miss_q, miss_d;
  logic [15:0]         hi_q, hi_d;
  logic [A_SPACE-1:0]  wtag;
  logic [NumLines-1:0] hit_v, we_v;
  logic [31:0]         data_v [NumLines];
  logic                hit;

`ifdef IMEM_PREFETCH_EN
  logic               pf_pend_q, pf_pend_d;
  logic               pf_sel_q, pf_sel_d;
  logic [A_SPACE-1:0] pf_addr_q, pf_addr_d;
`endif

  assign addr_tag = imem_addr[A_SPACE-1:0];

  for (genvar i = 0; i < NumLines; i++) begin : g_line
    openfire_imem_line #(
      .TagW(A_SPACE)
    ) u_line (
      .clk_i  (clock),
      .rst_i  (reset),
      .we_i   (we_v[i]),
      .wtag_i (wtag),
      .wdata_i({hi_q, xmem_rdata}),
      .addr_i (addr_tag),
      .hit_o  (hit_v[i]),
      .data_o (data_v[i])
    );
  end

  assign hit        = |hit_v;
  assign imem_stall = ~reset & ~hit;

  always_comb begin
    idata = NOP_WORD;
    for (int i = 0; i < int'(NumLines); i++) begin
      if (hit_v[i]) idata = data_v[i];
    end
    if (reset) idata = NOP_WORD;
  end

  always_comb begin
    state_d   = state_q;
    miss_d    = miss_q;
    hi_d      = hi_q;
    we_v      = '0;
    wtag      = miss_q;
    xmem_req  = 1'b0;
    xmem_addr = '0;
`ifdef IMEM_PREFETCH_EN
    pf_pend_d = pf_pend_q;
    pf_sel_d  = pf_sel_q;
    pf_addr_d = pf_addr_q;
`endif
    unique case (state_q)
      StIdle: begin
`ifdef IMEM_PREFETCH_EN
        // A pending prefetch always goes first; a miss is re-evaluated afterwards.
        if (pf_pend_q) begin
          state_d = StPfHi;
        end else if (!hit) begin
          miss_d  = addr_tag;
          state_d = StHi;
        end else if (hit_v[pf_sel_q]) begin
          pf_sel_d  = ~pf_sel_q;
          pf_pend_d = 1'b1;
          pf_addr_d = addr_tag + 1'b1;
        end
`else
        if (!hit) begin
          miss_d  = addr_tag;
          state_d = StHi;
        end
`endif
      end
      StHi: begin
        xmem_req  = 1'b1;
        xmem_addr = {miss_q, 1'b0};
        if (xmem_ack) begin
          hi_d    = xmem_rdata;
          state_d = StLo;
        end
      end
      StLo: begin
        xmem_req  = 1'b1;
        xmem_addr = {miss_q, 1'b1};
        if (xmem_ack) begin
`ifdef IMEM_PREFETCH_EN
          we_v[~pf_sel_q] = 1'b1;
          pf_pend_d       = 1'b1;
          pf_addr_d       = miss_q + 1'b1;
`else
          we_v[0] = 1'b1;
`endif
          state_d = StIdle;
        end
      end
`ifdef IMEM_PREFETCH_EN
      StPfHi: begin
        xmem_req  = 1'b1;
        xmem_addr = {pf_addr_q, 1'b0};
        if (xmem_ack) begin
          hi_d    = xmem_rdata;
          state_d = StPfLo;
        end
      end
      StPfLo: begin
        xmem_req  = 1'b1;
        xmem_addr = {pf_addr_q, 1'b1};
        wtag      = pf_addr_q;
        if (xmem_ack) begin
          we_v[pf_sel_q] = 1'b1;
          pf_pend_d      = 1'b0;
          state_d        = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      miss_q    <= '0;
      hi_q      <= '0;
`ifdef IMEM_PREFETCH_EN
      pf_pend_q <= 1'b0;
      pf_sel_q  <= 1'b1;
      pf_addr_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      miss_q    <= miss_d;
      hi_q      <= hi_d;
`ifdef IMEM_PREFETCH_EN
      pf_pend_q <= pf_pend_d;
      pf_sel_q  <= pf_sel_d;
      pf_addr_q <= pf_addr_d;
`endif
    end
  end

endmodule

// File: tb/tb_openfire_imem_ctrl.sv
// Directed and randomized checks of openfire_imem_ctrl against a line-buffer reference model.
module tb_openfire_imem_ctrl;

  localparam logic [31:0] Nop = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_addr, idata;
  logic        imem_stall, xmem_req;
  logic [16:0] xmem_addr;
  logic        xmem_ack;
  logic        resp_ack = 1'b0;
  logic        man_ack = 1'b0;
  logic [15:0] xmem_rdata = '0;

  logic [31:0] imem_addr2, idata2;
  logic        stall2, req2;
  logic [4:0]  xaddr2;
  logic        ack2 = 1'b0;
  logic [15:0] rdata2 = '0;

  logic [15:0] mem [256];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cfg_wait = 0;
  bit          resp_en = 1'b1;
  logic [16:0] acked [$];
  logic [4:0]  acked2 [$];

  // Reference model of the single line: what is buffered after each access.
  bit          m_valid = 1'b0;
  logic [15:0] m_tag = '0;

  always #5 clock = ~clock;
  assign xmem_ack = resp_ack | man_ack;

  openfire_imem_ctrl #(.A_SPACE(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .imem_addr (imem_addr),
    .idata     (idata),
    .imem_stall(imem_stall),
    .xmem_req  (xmem_req),
    .xmem_addr (xmem_addr),
    .xmem_ack  (xmem_ack),
    .xmem_rdata(xmem_rdata)
  );

  openfire_imem_ctrl #(.A_SPACE(4)) dut4 (
    .clock     (clock),
    .reset     (reset),
    .imem_addr (imem_addr2),
    .idata     (idata2),
    .imem_stall(stall2),
    .xmem_req  (req2),
    .xmem_addr (xaddr2),
    .xmem_ack  (ack2),
    .xmem_rdata(rdata2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory model with a programmable number of wait cycles per beat.
  int          wait_left = 0;
  bit          beat_new = 1'b1;
  logic [16:0] beat_addr = '0;
  always @(negedge clock) begin
    if (resp_ack) begin
      resp_ack = 1'b0;
      beat_new = 1'b1;
    end
    if (xmem_req === 1'b1 && resp_en && !reset) begin
      if (beat_new) begin
        wait_left = cfg_wait;
        beat_new  = 1'b0;
        beat_addr = xmem_addr;
      end else begin
        chk("xaddr_stable", {15'b0, xmem_addr}, {15'b0, beat_addr});
      end
      if (wait_left == 0) begin
        resp_ack   = 1'b1;
        xmem_rdata = mem[xmem_addr[7:0]];
        acked.push_back(xmem_addr);
      end else begin
        wait_left--;
      end
    end else begin
      beat_new = 1'b1;
    end
  end

  always @(negedge clock) begin
    ack2 = (req2 === 1'b1) && !reset;
    if (ack2) begin
      rdata2 = mem[{3'b0, xaddr2}];
      acked2.push_back(xaddr2);
    end
  end

  // One fetch request: counts stall cycles and checks data and beat addresses.
  // exp_in < 0 derives the expected stall from the single-line model.
  task automatic access(input logic [31:0] a, input int w, input bit late, input int exp_in,
                        input string tag);
    logic [15:0] t = a[15:0];
    logic [31:0] exp_d;
    int          exp_st;
    int          st = 0;
    exp_st = (exp_in >= 0) ? exp_in : ((m_valid && m_tag == t) ? 0 : 3 + 2 * w);
    exp_d  = {mem[{t[6:0], 1'b0}], mem[{t[6:0], 1'b1}]};
    cfg_wait = w;
    acked.delete();
    imem_addr = a;
    man_ack   = late;
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (imem_stall !== 1'b1) break;
      st++;
      @(posedge clock);
      #1;
      man_ack = 1'b0;
    end
    chk({tag, "_stall"}, st, exp_st);
    chk({tag, "_idata"}, idata, exp_d);
    if (exp_st != 0) begin
      chk({tag, "_beats"}, acked.size(), 2);
      if (acked.size() == 2) begin
        chk({tag, "_xa_hi"}, {15'b0, acked[0]}, {15'b0, t, 1'b0});
        chk({tag, "_xa_lo"}, {15'b0, acked[1]}, {15'b0, t, 1'b1});
      end
    end else begin
      chk({tag, "_nobeats"}, acked.size(), 0);
    end
    m_valid = 1'b1;
    m_tag   = t;
    @(posedge clock);
    #1;
    man_ack = 1'b0;
  endtask

  initial begin
    int          st2;
    logic [31:0] a;
    logic [15:0] word;
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0]     = 16'h8000;
    mem[1]     = 16'h0000;
    mem[8'h20] = 16'hB000;
    mem[8'h21] = 16'h0004;

    reset      = 1'b1;
    imem_addr  = '0;
    imem_addr2 = '0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_stall", {31'b0, imem_stall}, 32'd0);
    chk("rst_idata", idata, Nop);
    chk("rst_req", {31'b0, xmem_req}, 32'd0);
    chk("rst_xaddr", {15'b0, xmem_addr}, 32'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    access(32'h0, 0, 1'b0, -1, "w0");

`ifdef IMEM_PREFETCH_EN
    repeat (6) @(posedge clock);
    #1;
    chk("pf_done1", {31'b0, xmem_req}, 32'd0);
    access(32'h1, 0, 1'b0, 0, "pf1");
    repeat (6) @(posedge clock);
    #1;
    chk("pf_done2", {31'b0, xmem_req}, 32'd0);
    access(32'h2, 0, 1'b0, 0, "pf2");
    repeat (6) @(posedge clock);
    #1;
`else
    access(32'h10, 0, 1'b0, -1, "w10");
    imem_addr = 32'h10;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk("hold_stall", {31'b0, imem_stall}, 32'd0);
      chk("hold_req", {31'b0, xmem_req}, 32'd0);
      chk("hold_idata", idata, 32'hB000_0004);
      @(posedge clock);
      #1;
    end

    access(32'h20, 2, 1'b0, -1, "w20");

    // Reset while the low beat is still waiting on memory.
    cfg_wait = 3;
    acked.delete();
    imem_addr = 32'h30;
    for (int c = 0; c < 40; c++) begin
      @(posedge clock);
      if (acked.size() != 0) break;
    end
    #1;
    chk("mid_hi_beat", acked.size(), 1);
    chk("mid_req_lo", {31'b0, xmem_req}, 32'd1);
    chk("mid_xaddr_lo", {15'b0, xmem_addr}, 32'h61);
    reset   = 1'b1;
    resp_en = 1'b0;
    @(negedge clock);
    chk("mid_rst_stall", {31'b0, imem_stall}, 32'd0);
    chk("mid_rst_idata", idata, Nop);
    @(posedge clock);
    #1;
    chk("mid_req_drop", {31'b0, xmem_req}, 32'd0);
    reset   = 1'b0;
    resp_en = 1'b1;
    m_valid = 1'b0;
    access(32'h30, 0, 1'b1, -1, "refill");

    for (int n = 0; n < 16; n++) begin
      word = ($urandom_range(0, 1) == 0) ? m_tag : 16'($urandom_range(0, 127));
      a    = {16'($urandom), word};
      access(a, $urandom_range(0, 2), 1'b0, -1, "rnd");
    end
`endif

    // Narrow address space: upper address bits wrap away.
    acked2.delete();
    imem_addr2 = 32'h13;
    st2 = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (stall2 !== 1'b1) break;
      st2++;
      @(posedge clock);
      #1;
    end
    chk("a4_stall", st2, 3);
    chk("a4_beats", acked2.size(), 2);
    if (acked2.size() == 2) begin
      chk("a4_xa_hi", {27'b0, acked2[0]}, 32'd6);
      chk("a4_xa_lo", {27'b0, acked2[1]}, 32'd7);
    end
    chk("a4_idata", idata2, {mem[6], mem[7]});
    @(posedge clock);
    #1;
    imem_addr2 = 32'h3;
    @(negedge clock);
    chk("a4_alias_stall", {31'b0, stall2}, 32'd0);
    chk("a4_alias_idata", idata2, {mem[6], mem[7]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
